// File: rtl/drop_sequencer_if.sv
// Handshake bundle between the drop sequencer and its stimulus/decision side.
// master drives start/sensor/weight/answer; slave (the sequencer) drives timing and result pulses.
interface drop_sequencer_if;
    logic        start;
    logic        sensor_hit;
    logic [7:0]  weight;
    logic        drop_activated;
    logic [15:0] t_act;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        busy;
    logic        drop_ok;
    logic        drop_rej;
    logic        timeout;

    modport master (
        output start, sensor_hit, weight, drop_activated,
        input  t_act, t_lim, drop_en, busy, drop_ok, drop_rej, timeout
    );

    modport slave (
        input  start, sensor_hit, weight, drop_activated,
        output t_act, t_lim, drop_en, busy, drop_ok, drop_rej, timeout
    );
endinterface

// File: rtl/drop_sequencer.sv
// Measures sensor delay after start, then requests a drop for a bounded window; pulses ok/rej/timeout.
// All outputs registered; start is dropped (not queued) while busy, drop_activated is the only backpressure.
module drop_sequencer #(
    parameter logic [15:0] BASE_LIM   = 16'd100,
    parameter logic [7:0]  LIM_STEP   = 8'd2,
    parameter logic [15:0] MAX_WAIT   = 16'd60000,
    parameter int          ACK_WINDOW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    drop_sequencer_if.slave  bus
);
    localparam int WIN_W = (ACK_WINDOW > 1) ? $clog2(ACK_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ACK_WINDOW - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, REQUEST} state_t;

    state_t            state;
    logic [WIN_W-1:0]  win_cnt;
    logic [16:0]       lim_sum;
    logic [15:0]       lim_sat;

    // Worst case 0xFFFF + 255*255 still fits in 17 bits, so bit 16 alone flags overflow.
    assign lim_sum = {1'b0, BASE_LIM} + (17'(bus.weight) * 17'(LIM_STEP));
    assign lim_sat = lim_sum[16] ? 16'hFFFF : lim_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            win_cnt      <= '0;
            bus.t_act    <= 16'd0;
            bus.t_lim    <= 16'd0;
            bus.drop_en  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.drop_ok  <= 1'b0;
            bus.drop_rej <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            bus.drop_ok  <= 1'b0;
            bus.drop_rej <= 1'b0;
            bus.timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.t_act <= 16'd0;
                        bus.t_lim <= lim_sat;
                        bus.busy  <= 1'b1;
                        state     <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A sensor hit on the final allowed cycle still counts as a valid measurement.
                    if (bus.sensor_hit) begin
                        win_cnt     <= '0;
                        bus.drop_en <= 1'b1;
                        state       <= REQUEST;
                    end else if (bus.t_act == MAX_WAIT) begin
                        bus.timeout <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        bus.t_act <= bus.t_act + 16'd1;
                    end
                end
                REQUEST: begin
                    if (bus.drop_activated) begin
                        bus.drop_ok <= 1'b1;
                        bus.drop_en <= 1'b0;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end else if (win_cnt == WIN_LAST) begin
                        bus.drop_rej <= 1'b1;
                        bus.drop_en  <= 1'b0;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                default: begin
                    bus.drop_en <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_drop_sequencer.sv
// Three sequencer instances (default, short MAX_WAIT, near-saturating BASE_LIM) driven by directed vectors;
// a negedge monitor pops expected sequence results from a scoreboard queue whenever a result pulse appears.
module tb_drop_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // kind: 0 = drop_ok, 1 = drop_rej, 2 = timeout
    typedef struct {
        int inst;
        int kind;
        int tact;
        int tlim;
        int en;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   en_cnt[3];

    logic        start_d[3];
    logic        sensor_d[3];
    logic [7:0]  weight_d[3];
    logic [15:0] t_act_o[3];
    logic [15:0] t_lim_o[3];
    logic        drop_en_o[3];
    logic        busy_o[3];
    logic        ok_o[3];
    logic        rej_o[3];
    logic        tmo_o[3];

    drop_sequencer_if bus0 ();
    drop_sequencer_if bus1 ();
    drop_sequencer_if bus2 ();

    drop_sequencer u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    drop_sequencer #(.MAX_WAIT(16'd20)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    drop_sequencer #(.BASE_LIM(16'hFF00), .LIM_STEP(8'd2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Decision-stage model: accept whenever the measured time is within the limit.
    assign bus0.drop_activated = bus0.drop_en & (bus0.t_act <= bus0.t_lim);
    assign bus1.drop_activated = bus1.drop_en & (bus1.t_act <= bus1.t_lim);
    assign bus2.drop_activated = bus2.drop_en & (bus2.t_act <= bus2.t_lim);

    assign bus0.start = start_d[0];  assign bus0.sensor_hit = sensor_d[0];  assign bus0.weight = weight_d[0];
    assign bus1.start = start_d[1];  assign bus1.sensor_hit = sensor_d[1];  assign bus1.weight = weight_d[1];
    assign bus2.start = start_d[2];  assign bus2.sensor_hit = sensor_d[2];  assign bus2.weight = weight_d[2];

    assign t_act_o[0] = bus0.t_act;  assign t_lim_o[0] = bus0.t_lim;  assign drop_en_o[0] = bus0.drop_en;
    assign t_act_o[1] = bus1.t_act;  assign t_lim_o[1] = bus1.t_lim;  assign drop_en_o[1] = bus1.drop_en;
    assign t_act_o[2] = bus2.t_act;  assign t_lim_o[2] = bus2.t_lim;  assign drop_en_o[2] = bus2.drop_en;
    assign busy_o[0] = bus0.busy;  assign ok_o[0] = bus0.drop_ok;  assign rej_o[0] = bus0.drop_rej;  assign tmo_o[0] = bus0.timeout;
    assign busy_o[1] = bus1.busy;  assign ok_o[1] = bus1.drop_ok;  assign rej_o[1] = bus1.drop_rej;  assign tmo_o[1] = bus1.timeout;
    assign busy_o[2] = bus2.busy;  assign ok_o[2] = bus2.drop_ok;  assign rej_o[2] = bus2.drop_rej;  assign tmo_o[2] = bus2.timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input int kind, input int tact, input int tlim, input int en);
        exp_t x;
        x.inst = inst; x.kind = kind; x.tact = tact; x.tlim = tlim; x.en = en;
        sb_q.push_back(x);
    endtask

    // Leaves the bench in MEASURE cycle 1 of instance i.
    task automatic begin_seq(input int i, input logic [7:0] w, input logic hit_now);
        start_d[i]  = 1'b1;
        weight_d[i] = w;
        sensor_d[i] = hit_now;
        tick();
        start_d[i]  = 1'b0;
        sensor_d[i] = 1'b0;
    endtask

    // From MEASURE cycle 1, raise sensor_hit during MEASURE cycle n; leaves the bench in REQUEST cycle 1.
    task automatic hit_at(input int i, input int n);
        repeat (n - 1) tick();
        sensor_d[i] = 1'b1;
        tick();
        sensor_d[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k = 0;
        while (busy_o[i] && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("idle_reached_inst%0d", i), 32'(busy_o[i]), 32'd0);
    endtask

    // Result monitor: every ok/rej/timeout pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                en_cnt[i] = 0;
            end else begin
                if (drop_en_o[i]) en_cnt[i]++;
                if (ok_o[i] || rej_o[i] || tmo_o[i]) begin
                    check("pulse_exclusive", 32'(ok_o[i]) + 32'(rej_o[i]) + 32'(tmo_o[i]), 32'd1);
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pulse inst%0d: got ok=%0b rej=%0b tmo=%0b, required none",
                                 i, ok_o[i], rej_o[i], tmo_o[i]);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_inst", 32'(i), 32'(e.inst));
                        check("sb_kind", ok_o[i] ? 32'd0 : (rej_o[i] ? 32'd1 : 32'd2), 32'(e.kind));
                        check("sb_t_act", 32'(t_act_o[i]), 32'(e.tact));
                        check("sb_t_lim", 32'(t_lim_o[i]), 32'(e.tlim));
                        check("sb_drop_en_cycles", 32'(en_cnt[i]), 32'(e.en));
                        check("sb_drop_en_low", 32'(drop_en_o[i]), 32'd0);
                    end
                    en_cnt[i] = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_d[i] = 1'b0; sensor_d[i] = 1'b0; weight_d[i] = 8'd0; en_cnt[i] = 0;
        end

        // Reset with random inputs
        repeat (3) begin
            for (int i = 0; i < 3; i++) begin
                start_d[i]  = 1'($urandom_range(0, 1));
                sensor_d[i] = 1'($urandom_range(0, 1));
                weight_d[i] = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check("rst_t_act", 32'(t_act_o[i]), 32'd0);
                check("rst_t_lim", 32'(t_lim_o[i]), 32'd0);
                check("rst_outs", {27'd0, drop_en_o[i], busy_o[i], ok_o[i], rej_o[i], tmo_o[i]}, 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            start_d[i] = 1'b0; sensor_d[i] = 1'b0; weight_d[i] = 8'd0;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) check("post_rst_idle", 32'(busy_o[i]), 32'd0);

        // weight 50 -> limit 200; hit in MEASURE cycle 151 -> t_act 150, accepted at once
        push(0, 0, 150, 200, 1);
        begin_seq(0, 8'd50, 1'b1);
        check("t1_t_act0", 32'(t_act_o[0]), 32'd0);
        check("t1_t_lim", 32'(t_lim_o[0]), 32'd200);
        check("t1_busy", 32'(busy_o[0]), 32'd1);
        hit_at(0, 151);
        check("t1_drop_en", 32'(drop_en_o[0]), 32'd1);
        check("t1_t_act", 32'(t_act_o[0]), 32'd150);
        wait_idle(0, 10);

        // weight 10 -> limit 120; 150 > 120 so full 4-cycle window then reject; start on the exit edge is dropped
        push(0, 1, 150, 120, 4);
        begin_seq(0, 8'd10, 1'b0);
        check("t2_t_lim", 32'(t_lim_o[0]), 32'd120);
        hit_at(0, 151);
        repeat (3) tick();
        check("t2_drop_en_c4", 32'(drop_en_o[0]), 32'd1);
        start_d[0]  = 1'b1;
        weight_d[0] = 8'd99;
        tick();
        start_d[0]  = 1'b0;
        check("t2_busy_exit", 32'(busy_o[0]), 32'd0);
        tick();
        check("t2_start_ignored", 32'(busy_o[0]), 32'd0);
        repeat (5) tick();
        check("t2_hold_t_act", 32'(t_act_o[0]), 32'd150);
        check("t2_hold_t_lim", 32'(t_lim_o[0]), 32'd120);

        // MAX_WAIT 20, no sensor -> timeout with t_act 20
        push(1, 2, 20, 100, 0);
        begin_seq(1, 8'd0, 1'b0);
        wait_idle(1, 40);
        check("t3_t_act", 32'(t_act_o[1]), 32'd20);
        check("t3_drop_en", 32'(drop_en_o[1]), 32'd0);

        // sensor in the cycle t_act == 20 wins over timeout
        push(1, 0, 20, 100, 1);
        begin_seq(1, 8'd0, 1'b0);
        hit_at(1, 21);
        check("t3b_drop_en", 32'(drop_en_o[1]), 32'd1);
        check("t3b_t_act", 32'(t_act_o[1]), 32'd20);
        wait_idle(1, 10);

        // 0xFF00 + 510 saturates; second start mid-measurement is ignored
        push(2, 0, 4, 32'hFFFF, 1);
        begin_seq(2, 8'd255, 1'b0);
        check("t4_t_lim_sat", 32'(t_lim_o[2]), 32'hFFFF);
        tick();
        start_d[2]  = 1'b1;
        weight_d[2] = 8'd0;
        tick();
        start_d[2]  = 1'b0;
        check("t4_t_lim_kept", 32'(t_lim_o[2]), 32'hFFFF);
        check("t4_t_act_kept", 32'(t_act_o[2]), 32'd2);
        check("t4_busy", 32'(busy_o[2]), 32'd1);
        hit_at(2, 3);
        wait_idle(2, 10);

        // Async reset in REQUEST (t_act 120 > limit 100, so no ack pending)
        begin_seq(0, 8'd0, 1'b0);
        hit_at(0, 121);
        check("t5_in_request", 32'(drop_en_o[0]), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_drop_en", 32'(drop_en_o[0]), 32'd0);
        check("t5_async_t_act", 32'(t_act_o[0]), 32'd0);
        check("t5_async_busy", 32'(busy_o[0]), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("t5_no_pulse", {30'd0, ok_o[0], rej_o[0]}, 32'd0);
        check("t5_stay_idle", 32'(busy_o[0]), 32'd0);

        push(0, 0, 10, 200, 1);
        begin_seq(0, 8'd50, 1'b0);
        hit_at(0, 11);
        wait_idle(0, 10);

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
- Timing/handshake front end that produces t_act, t_lim and drop_en for the display/drop decision stage, and consumes its drop_activated answer.
- On a start pulse it latches a weight-derived time limit, counts clock cycles until the baggage sensor fires, then raises drop_en and waits a bounded window for drop_activated.
- It reports drop success, rejection or timeout as single-cycle pulses.
- It holds t_act and t_lim after the sequence so the display keeps showing the last verdict.

Parameters:
- BASE_LIM, 16'd100, base time limit in cycles.
- LIM_STEP, 8'd2, limit cycles added per unit of weight.
- MAX_WAIT, 16'd60000, maximum t_act before the measurement is aborted.
- ACK_WINDOW, 4, number of cycles drop_en stays high waiting for drop_activated; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sequence; ignored while busy.
- sensor_hit  input  1  baggage sensor event; valid only in MEASURE.
- weight  input  8  baggage weight, sampled on the accepted start.
- drop_activated  input  1  answer from the display/drop stage; combinational on its side.
- t_act  output  16  measured cycle count, registered.
- t_lim  output  16  latched time limit, registered.
- drop_en  output  1  drop request, registered, high only in REQUEST.
- busy  output  1  high in MEASURE and REQUEST.
- drop_ok  output  1  one-cycle pulse: drop accepted.
- drop_rej  output  1  one-cycle pulse: no acknowledge within ACK_WINDOW.
- timeout  output  1  one-cycle pulse: sensor never fired.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; t_act, t_lim, the window counter and all 1-bit outputs are 0. Releasing reset mid-operation does not resume the sequence; the block waits in IDLE for a new start.
- States: IDLE, MEASURE, REQUEST. busy = (state != IDLE). drop_en = (state == REQUEST), driven from a register.
- IDLE:
  - t_act and t_lim hold their values.
  - On start=1 at an edge: t_act <= 0; t_lim <= min(BASE_LIM + weight*LIM_STEP, 16'hFFFF), computed at 17+ bits and saturated; go to MEASURE.
- MEASURE:
  - Any sensor_hit in the cycle start is accepted is ignored; MEASURE begins on the next cycle.
  - At each edge with sensor_hit=1: t_act holds; go to REQUEST; clear the window counter.
  - Otherwise, if t_act == MAX_WAIT: pulse timeout for one cycle; go to IDLE. drop_en is never raised.
  - Otherwise: t_act <= t_act + 1.
  - If sensor_hit and the MAX_WAIT condition occur in the same cycle, sensor_hit wins.
  - Result: sensor_hit first seen in the Nth MEASURE cycle gives t_act = N-1.
- REQUEST (drop_en=1):
  - At each edge, drop_activated is sampled.
  - drop_activated=1: pulse drop_ok for one cycle; go to IDLE.
  - Else, if the window counter == ACK_WINDOW-1: pulse drop_rej for one cycle; go to IDLE.
  - Else: increment the window counter.
  - drop_en is therefore high for 1..ACK_WINDOW cycles.
  - drop_en falls in the same cycle the ok/rej pulse rises.
- start is ignored in MEASURE and REQUEST. start in the same cycle as a return to IDLE is also ignored; it must arrive while IDLE is registered.
- drop_ok, drop_rej and timeout are mutually exclusive, and at most one pulses per sequence.
- t_act and t_lim never change outside a sequence; they hold until the next accepted start.

Test Plan:
- Assert rst_n=0 with random inputs -> t_act=0, t_lim=0, and drop_en, busy, drop_ok, drop_rej, timeout all 0; after release the block stays in IDLE until start.
- Defaults, weight=50, start, sensor_hit in MEASURE cycle 151; bench model drives drop_activated = drop_en & (t_act <= t_lim) -> t_lim=200, t_act=150, drop_en high exactly 1 cycle, then drop_ok pulses 1 cycle, busy falls.
- weight=10, sensor_hit in MEASURE cycle 151, same model -> t_lim=120, t_act=150, drop_activated stays 0, drop_en high exactly 4 cycles, drop_rej pulses once, t_act/t_lim hold afterwards.
- MAX_WAIT=20, no sensor_hit -> t_act counts to 20, timeout pulses on the next edge, state returns to IDLE, drop_en never asserted. Repeat with sensor_hit in the same cycle t_act==20 -> REQUEST entered, no timeout.
- BASE_LIM=16'hFF00, LIM_STEP=2, weight=255 -> t_lim=16'hFFFF (saturated). A second start pulse during MEASURE is ignored and t_lim is unchanged.
- rst_n low for 1 cycle while in REQUEST -> drop_en drops without waiting for a clock edge, t_act=0, no ok/rej pulse; a following start runs a normal sequence.
